garegga_gfx_line_fetch: RTL and testbench

//  Burst sequencer between the GP9001 sprite/tile line renderer and one 32-bit GFX ROM slot of
//  the SDRAM bank-1 slot arbiter. Accepts a (start address, word count) request, issues the

---
 rtl/garegga_pkg.sv | 17 +
 rtl/garegga_gfx_fifo.sv | 73 +++++++
 rtl/garegga_gfx_line_fetch.sv | 127 ++++++++++++
 tb/tb_garegga_gfx_line_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/garegga_pkg.sv
// Shared definitions for the Garegga GFX line fetch path: the burst sequencer state
// encoding and the default widths of the bank-1 GFX ROM slot.
package garegga_pkg;

    localparam int GFX_AW        = 22;  // slot address width, 16-bit word units
    localparam int GFX_DW        = 32;  // slot data width
    localparam int GFX_LEN_W     = 4;   // burst length field width (length minus one)
    localparam int GFX_FIFO_LOG2 = 4;   // line FIFO depth exponent
    localparam int GFX_ADDR_STEP = 2;   // two 16-bit words per 32-bit fetch

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/garegga_gfx_fifo.sv
// Single-clock first-word-fall-through FIFO between the slot sequencer and the renderer.
// The head word is read straight out of the storage array so it is visible the cycle after
// it was written; the array is small enough that distributed RAM is the natural fit.
module garegga_gfx_fifo
    import garegga_pkg::*;
#(
    parameter int DW   = GFX_DW,
    parameter int LOG2 = GFX_FIFO_LOG2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FLUSH,
    input  logic            PUSH,
    input  logic [DW-1:0]   WDATA,
    input  logic            POP,
    output logic [DW-1:0]   DOUT,
    output logic            EMPTY,
    output logic            FULL,
    output logic [LOG2:0]   LEVEL
);

    localparam int DEPTH = 2 ** LOG2;
    localparam int LW    = LOG2 + 1;

    logic [DW-1:0]   mem [DEPTH];
    logic [LOG2-1:0] wr_ptr_reg;
    logic [LOG2-1:0] rd_ptr_reg;
    logic [LOG2:0]   level_reg;
    logic            push_en;
    logic            pop_en;

    assign EMPTY   = (level_reg == '0);
    assign FULL    = (level_reg == LW'(DEPTH));
    assign LEVEL   = level_reg;
    // Writes into a full FIFO and reads from an empty one are dropped; a flush wins over both.
    assign push_en = PUSH && !FULL && !FLUSH;
    assign pop_en  = POP && !EMPTY && !FLUSH;
    // Invalid head reads as zero so the output is defined straight out of reset.
    assign DOUT    = EMPTY ? '0 : mem[rd_ptr_reg];

    // Storage write; contents need no reset because EMPTY masks them.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= WDATA;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the depth.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (FLUSH) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + LOG2'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + LOG2'(1);
            end
            if (push_en && !pop_en) begin
                level_reg <= level_reg + LW'(1);
            end else if (pop_en && !push_en) begin
                level_reg <= level_reg - LW'(1);
            end
        end
    end

endmodule

// File: rtl/garegga_gfx_line_fetch.sv
// Burst sequencer for one GFX ROM slot: turns a (start, length) request from the line
// renderer into single-word slot accesses and parks the returned words in a FIFO that the
// renderer drains at pixel rate. Only one slot access is ever outstanding, and a GAP cycle
// after every accepted word lets the slot's ok flag drop before the next address appears.
module garegga_gfx_line_fetch
    import garegga_pkg::*;
#(
    parameter int AW        = GFX_AW,
    parameter int DW        = GFX_DW,
    parameter int LEN_W     = GFX_LEN_W,
    parameter int FIFO_LOG2 = GFX_FIFO_LOG2,
    parameter int ADDR_STEP = GFX_ADDR_STEP
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 REQ,
    input  logic [AW-1:0]        REQ_ADDR,
    input  logic [LEN_W-1:0]     REQ_LEN,
    input  logic                 ABORT,
    output logic                 REQ_BUSY,
    input  logic                 POP,
    output logic [DW-1:0]        DOUT,
    output logic                 EMPTY,
    output logic [FIFO_LOG2:0]   LEVEL,
    output logic                 GFX_CS,
    output logic [AW-1:0]        GFX_ADDR,
    input  logic                 GFX_OK,
    input  logic [DW-1:0]        GFX_DATA
);

    fetch_state_t     state_reg;
    logic [AW-1:0]    addr_reg;
    logic [LEN_W-1:0] count_reg;
    logic             cs_reg;
    logic             busy_reg;
    logic             fifo_full;
    logic             accept_ok;

    // A slot word is taken only while our request is actually on the bus; an ok that lands
    // in an abort cycle belongs to the cancelled line and is dropped.
    assign accept_ok = (state_reg == ST_ISSUE) && cs_reg && GFX_OK && !ABORT;

    garegga_gfx_fifo #(
        .DW   (DW),
        .LOG2 (FIFO_LOG2)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .FLUSH (ABORT),
        .PUSH  (accept_ok),
        .WDATA (GFX_DATA),
        .POP   (POP),
        .DOUT  (DOUT),
        .EMPTY (EMPTY),
        .FULL  (fifo_full),
        .LEVEL (LEVEL)
    );

    // Burst FSM with registered chip select, address and busy flag. Chip select is only
    // raised when the FIFO has room for the word, so a push can never hit a full FIFO.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            count_reg <= '0;
            cs_reg    <= 1'b0;
            busy_reg  <= 1'b0;
        end else if (ABORT) begin
            // Abort drops the bus request; a simultaneous REQ restarts from a clean FIFO,
            // and chip select comes back from ISSUE one cycle later.
            cs_reg <= 1'b0;
            if (REQ) begin
                addr_reg  <= REQ_ADDR;
                count_reg <= REQ_LEN;
                state_reg <= ST_ISSUE;
                busy_reg  <= 1'b1;
            end else begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (REQ) begin
                        addr_reg  <= REQ_ADDR;
                        count_reg <= REQ_LEN;
                        cs_reg    <= !fifo_full;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cs_reg) begin
                        if (GFX_OK) begin
                            cs_reg <= 1'b0;
                            if (count_reg == '0) begin
                                busy_reg  <= 1'b0;
                                state_reg <= ST_IDLE;
                            end else begin
                                addr_reg  <= addr_reg + AW'(ADDR_STEP);
                                count_reg <= count_reg - LEN_W'(1);
                                state_reg <= ST_GAP;
                            end
                        end
                    end else begin
                        // Waiting for FIFO room; address stays put.
                        cs_reg <= !fifo_full;
                    end
                end
                ST_GAP: begin
                    cs_reg    <= !fifo_full;
                    state_reg <= ST_ISSUE;
                end
                default: begin
                    cs_reg    <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign REQ_BUSY = busy_reg;
    assign GFX_CS   = cs_reg;
    assign GFX_ADDR = addr_reg;

endmodule

// File: tb/tb_garegga_gfx_line_fetch.sv
// Self-checking bench for the GFX line fetch sequencer. The bench plays the SDRAM slot
// (random latency, spurious ok pulses while chip select is low) and keeps a word-level
// model: the expected address stream of each burst and a queue of words awaiting the renderer.
module tb_garegga_gfx_line_fetch;

    localparam int AW    = 22;
    localparam int DW    = 32;
    localparam int LEN_W = 4;
    localparam int FLOG  = 3;
    localparam int DEPTH = 8;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             REQ;
    logic [AW-1:0]    REQ_ADDR;
    logic [LEN_W-1:0] REQ_LEN;
    logic             ABORT;
    logic             REQ_BUSY;
    logic             POP;
    logic [DW-1:0]    DOUT;
    logic             EMPTY;
    logic [FLOG:0]    LEVEL;
    logic             GFX_CS;
    logic [AW-1:0]    GFX_ADDR;
    logic             GFX_OK;
    logic [DW-1:0]    GFX_DATA;

    garegga_gfx_line_fetch #(
        .AW(AW), .DW(DW), .LEN_W(LEN_W), .FIFO_LOG2(FLOG), .ADDR_STEP(2)
    ) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
        .ABORT(ABORT), .REQ_BUSY(REQ_BUSY), .POP(POP), .DOUT(DOUT), .EMPTY(EMPTY),
        .LEVEL(LEVEL), .GFX_CS(GFX_CS), .GFX_ADDR(GFX_ADDR), .GFX_OK(GFX_OK),
        .GFX_DATA(GFX_DATA)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // model state
    logic [DW-1:0] q_exp[$];
    logic [AW-1:0] addr_log[$];
    logic [AW-1:0] next_addr;
    int            words_left;
    bit            busy_m;
    bit            cs_prev;
    bit            ok_acc;
    int            lat_left;
    int            issued_cnt;
    bit            sched_v[2];
    bit            sched_e[2];
    // stimulus knobs
    int            pop_pct;
    int            lat_lo;
    int            lat_hi;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return {a[15:0], a[21:6]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic model_reset();
        q_exp.delete();
        busy_m     = 0;
        words_left = 0;
        cs_prev    = 0;
        ok_acc     = 0;
        lat_left   = 0;
        sched_v[0] = 0;
        sched_v[1] = 0;
    endtask

    task automatic start_burst(input logic [AW-1:0] a, input logic [LEN_W-1:0] len);
        busy_m     = 1;
        next_addr  = a;
        words_left = int'(len) + 1;
        addr_log.delete();
    endtask

    // One clock cycle: check what the DUT shows now, drive this cycle's inputs, advance model.
    task automatic do_cycle(input bit req, input logic [AW-1:0] a,
                            input logic [LEN_W-1:0] len, input bit abort);
        bit            ok;
        bit            pop;
        bit            pre_busy;
        int            pre_size;
        logic [DW-1:0] data;

        pre_size = q_exp.size();
        chk("level", LEVEL, pre_size);
        chk("empty", EMPTY, pre_size == 0);
        chk("busy", REQ_BUSY, busy_m);
        if (!busy_m) chk("cs_idle", GFX_CS, 0);
        if (ok_acc) chk("cs_gap", GFX_CS, 0);
        if (GFX_CS) chk("cs_room", LEVEL < DEPTH, 1);
        if (sched_v[0]) chk("cs_sched", GFX_CS, sched_e[0]);
        if (GFX_CS) begin
            chk("addr", GFX_ADDR, next_addr);
            if (!cs_prev) begin
                issued_cnt++;
                addr_log.push_back(GFX_ADDR);
                lat_left = $urandom_range(lat_hi, lat_lo);
            end
        end

        ok   = 0;
        data = $urandom;
        if (GFX_CS) begin
            if (lat_left == 0) begin
                ok   = 1;
                data = rom(next_addr);
            end else begin
                lat_left--;
            end
        end else begin
            ok = ($urandom_range(3, 0) == 0);
        end
        pop = ($urandom_range(99, 0) < pop_pct);
        if (pop && pre_size > 0) chk("dout", DOUT, q_exp[0]);

        REQ      = req;
        REQ_ADDR = a;
        REQ_LEN  = len;
        ABORT    = abort;
        POP      = pop;
        GFX_OK   = ok;
        GFX_DATA = data;

        pre_busy   = busy_m;
        sched_v[0] = sched_v[1];
        sched_e[0] = sched_e[1];
        sched_v[1] = 0;
        if (abort) begin
            q_exp.delete();
            ok_acc     = 0;
            sched_v[0] = 1;
            sched_e[0] = 0;
            if (req) begin
                start_burst(a, len);
                sched_v[1] = 1;
                sched_e[1] = 1;
            end else begin
                busy_m     = 0;
                words_left = 0;
            end
        end else begin
            if (pop && pre_size > 0) void'(q_exp.pop_front());
            ok_acc = GFX_CS && ok;
            if (ok_acc) begin
                q_exp.push_back(rom(next_addr));
                next_addr = next_addr + AW'(2);
                words_left--;
                if (words_left == 0) busy_m = 0;
            end
            if (req && !pre_busy) begin
                start_burst(a, len);
                sched_v[0] = 1;
                sched_e[0] = (pre_size < DEPTH);
            end
        end
        cs_prev = GFX_CS;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, '0, '0, 0);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy_m || REQ_BUSY) && n < bound) begin
            do_cycle(0, '0, '0, 0);
            n++;
        end
        chk("idle_timeout", REQ_BUSY, 0);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        int saved = pop_pct;
        pop_pct = 100;
        while ((busy_m || REQ_BUSY || q_exp.size() > 0) && n < bound) begin
            do_cycle(0, '0, '0, 0);
            n++;
        end
        chk("drain_timeout", EMPTY, 1);
        pop_pct = saved;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, REQ_BUSY, 0);
        chk({tag, "_cs"}, GFX_CS, 0);
        chk({tag, "_addr"}, GFX_ADDR, 0);
        chk({tag, "_empty"}, EMPTY, 1);
        chk({tag, "_level"}, LEVEL, 0);
        chk({tag, "_dout"}, DOUT, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] ra;
        int            n;

        RESET = 1; REQ = 0; REQ_ADDR = '0; REQ_LEN = '0; ABORT = 0; POP = 0;
        GFX_OK = 0; GFX_DATA = '0;
        issued_cnt = 0; pop_pct = 0; lat_lo = 0; lat_hi = 0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("rst0");
        RESET = 0;
        idle_cycles(2);

        // Fixed 3-cycle slot latency, 4-word burst at 0x100.
        lat_lo = 3; lat_hi = 3; pop_pct = 0;
        do_cycle(1, 22'h000100, 4'd3, 0);
        wait_idle(200);
        chk("t2_count", addr_log.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_addr%0d", i), addr_log[i], 22'h100 + 2 * i);
        drain(100);

        // Address wrap at the top of the slot space.
        lat_lo = 0; lat_hi = 2;
        do_cycle(1, 22'h3FFFFE, 4'd1, 0);
        wait_idle(100);
        chk("t4_count", addr_log.size(), 2);
        chk("t4_wrap", addr_log[1], 22'h000000);
        drain(100);

        // 16-word burst against an 8-deep FIFO with no reader.
        lat_lo = 0; lat_hi = 1; pop_pct = 0;
        do_cycle(1, 22'h012340, 4'd15, 0);
        n = issued_cnt;
        idle_cycles(60);
        chk("t3_level_full", LEVEL, 8);
        chk("t3_issues_full", issued_cnt - n, 8);
        pop_pct = 100;
        idle_cycles(1);
        pop_pct = 0;
        idle_cycles(20);
        chk("t3_issues_one_pop", issued_cnt - n, 9);
        chk("t3_level_refill", LEVEL, 8);
        drain(400);
        chk("t3_total", issued_cnt - n, 16);

        // Abort with a new request while five words sit in the FIFO and ok is on the bus.
        lat_lo = 0; lat_hi = 0; pop_pct = 0;
        do_cycle(1, 22'h020000, 4'd15, 0);
        n = 0;
        while (!(q_exp.size() == 5 && GFX_CS) && n < 100) begin
            do_cycle(0, '0, '0, 0);
            n++;
        end
        chk("t5_reached", LEVEL, 5);
        do_cycle(1, 22'h030000, 4'd3, 1);
        chk("t5_level", LEVEL, 0);
        chk("t5_cs_low", GFX_CS, 0);
        idle_cycles(3);
        do_cycle(1, 22'h2AAAA0, 4'd5, 0);
        wait_idle(200);
        chk("t5_count", addr_log.size(), 4);
        chk("t5_first", addr_log[0], 22'h030000);
        drain(100);

        // Renderer popping every cycle, slot answering immediately.
        lat_lo = 0; lat_hi = 0; pop_pct = 100;
        idle_cycles(3);
        do_cycle(1, 22'h055550, 4'd15, 0);
        wait_idle(200);
        idle_cycles(3);
        chk("t6_level", LEVEL, 0);

        // Asynchronous reset in the middle of a burst.
        lat_lo = 2; lat_hi = 4; pop_pct = 0;
        do_cycle(1, 22'h001000, 4'd7, 0);
        idle_cycles(4);
        #3;
        RESET = 1;
        #1;
        check_reset_outputs("t1");
        REQ = 0; ABORT = 0; POP = 0; GFX_OK = 0;
        @(posedge CLK);
        #1;
        RESET = 0;
        model_reset();
        idle_cycles(2);

        // Random bursts with random latency, reader rate, aborts and ignored requests.
        for (int b = 0; b < 40; b++) begin
            lat_lo  = 0;
            lat_hi  = $urandom_range(4, 0);
            pop_pct = $urandom_range(100, 10);
            ra      = AW'($urandom);
            do_cycle(1, ra, LEN_W'($urandom_range(15, 0)), 0);
            n = 0;
            while ((busy_m || REQ_BUSY) && n < 2000) begin
                case ($urandom_range(39, 0))
                    0:       do_cycle($urandom_range(1, 0) == 1, AW'($urandom),
                                      LEN_W'($urandom_range(15, 0)), 1);
                    1:       do_cycle(1, AW'($urandom), LEN_W'($urandom_range(15, 0)), 0);
                    default: do_cycle(0, '0, '0, 0);
                endcase
                n++;
            end
            chk("rand_idle", REQ_BUSY, 0);
            idle_cycles($urandom_range(3, 0));
        end
        drain(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
